// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Holds default geometry, the zero-register index and a popcount helper.
package regfile_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int R0_IDX    = 0;

    // Count of set bits, used to cross-check the pending-producer count.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, writeback port, issue/flush and status.
// master drives addresses/write/issue; slave (the regfile) returns data/busy.
interface regfile_sb_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic [AW-1:0]    Ra;
    logic [AW-1:0]    Rb;
    logic [WIDTH-1:0] Qa;
    logic [WIDTH-1:0] Qb;
    logic             Busy_a;
    logic             Busy_b;
    logic             We;
    logic [AW-1:0]    Wr;
    logic [WIDTH-1:0] D;
    logic             Iss;
    logic [AW-1:0]    Ird;
    logic             Flush;
    logic [AW:0]      Npend;

    modport master (
        output Ra, Rb, We, Wr, D, Iss, Ird, Flush,
        input  Qa, Qb, Busy_a, Busy_b, Npend
    );

    modport slave (
        input  Ra, Rb, We, Wr, D, Iss, Ird, Flush,
        output Qa, Qb, Busy_a, Busy_b, Npend
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with a running busy count.
// In: Clk, Clrn, Iss/Ird, wen/Wr, Flush, Ra/Rb, hit_a/hit_b. Out: Busy_a/b, Npend.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          Iss,
    input  logic [AW-1:0] Ird,
    input  logic          wen,
    input  logic [AW-1:0] Wr,
    input  logic          Flush,
    input  logic [AW-1:0] Ra,
    input  logic [AW-1:0] Rb,
    input  logic          hit_a,
    input  logic          hit_b,
    output logic          Busy_a,
    output logic          Busy_b,
    output logic [AW:0]   Npend
);

    localparam int DEPTH = 2 ** AW;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      npend_q;
    logic [AW:0]      npend_d;
    logic             iss_ok;
    logic             inc;
    logic             dec;

    assign iss_ok = Iss & ~(ZERO_R0 && (Ird == AW'(R0_IDX)));

    // Set is applied last so a new producer beats both clears.
    always_comb begin
        busy_d = busy_q;
        if (Flush) begin
            busy_d = '0;
        end
        if (wen) begin
            busy_d[Wr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[Ird] = 1'b1;
        end
    end

    // Count only real 0->1 / 1->0 transitions so Npend tracks popcount.
    // A writeback clear re-set by an issue to the same register is no change.
    assign inc = iss_ok & ~busy_q[Ird];
    assign dec = wen & busy_q[Wr] & ~(iss_ok & (Ird == Wr));

    always_comb begin
        npend_d = npend_q;
        if (Flush) begin
            npend_d = (AW+1)'(iss_ok);
        end else if (inc & ~dec) begin
            npend_d = npend_q + (AW+1)'(1);
        end else if (dec & ~inc) begin
            npend_d = npend_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            busy_q  <= '0;
            npend_q <= '0;
        end else begin
            busy_q  <= busy_d;
            npend_q <= npend_d;
        end
    end

    assign Busy_a = busy_q[Ra] & ~hit_a & ~(ZERO_R0 && (Ra == AW'(R0_IDX)));
    assign Busy_b = busy_q[Rb] & ~hit_b & ~(ZERO_R0 && (Rb == AW'(R0_IDX)));
    assign Npend  = npend_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with bypass and hazard scoreboard.
// Ports: Clk, Clrn (async active-low), bus (regfile_sb_if.slave).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int AW      = AW_DEF,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic         Clk,
    input  logic         Clrn,
    regfile_sb_if.slave  bus
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wen;
    logic             hit_a;
    logic             hit_b;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;

    assign wen   = bus.We & ~(ZERO_R0 && (bus.Wr == AW'(R0_IDX)));
    assign hit_a = BYPASS & wen & (bus.Wr == bus.Ra);
    assign hit_b = BYPASS & wen & (bus.Wr == bus.Rb);

    always_comb begin
        regs_d = regs_q;
        if (wen) begin
            regs_d[bus.Wr] = bus.D;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        qa = regs_q[bus.Ra];
        if (ZERO_R0 && (bus.Ra == AW'(R0_IDX))) begin
            qa = '0;
        end else if (hit_a) begin
            qa = bus.D;
        end
    end

    always_comb begin
        qb = regs_q[bus.Rb];
        if (ZERO_R0 && (bus.Rb == AW'(R0_IDX))) begin
            qb = '0;
        end else if (hit_b) begin
            qb = bus.D;
        end
    end

    assign bus.Qa = qa;
    assign bus.Qb = qb;

    rf_scoreboard #(
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .Clk    (Clk),
        .Clrn   (Clrn),
        .Iss    (bus.Iss),
        .Ird    (bus.Ird),
        .wen    (wen),
        .Wr     (bus.Wr),
        .Flush  (bus.Flush),
        .Ra     (bus.Ra),
        .Rb     (bus.Rb),
        .hit_a  (hit_a),
        .hit_b  (hit_b),
        .Busy_a (bus.Busy_a),
        .Busy_b (bus.Busy_b),
        .Npend  (bus.Npend)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reads, bypass, r0, scoreboard, reset.
// Drives at posedge+1, checks combinational outputs a step later.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic Clk;
    logic Clrn;
    int   errors;
    int   checks;

    regfile_sb_if #(.WIDTH(32), .AW(5)) bus ();

    regfile_sb #(
        .WIDTH   (32),
        .AW      (5),
        .ZERO_R0 (1'b1),
        .BYPASS  (1'b1)
    ) u_dut (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.We    = 1'b0;
        bus.Iss   = 1'b0;
        bus.Flush = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Clrn      = 1'b0;
        bus.Ra    = '0;
        bus.Rb    = '0;
        bus.Wr    = '0;
        bus.D     = '0;
        bus.Ird   = '0;
        idle();

        // reset state
        bus.Ra = 5'd5;
        bus.Rb = 5'd31;
        #2;
        chk("rst_qa", bus.Qa, 32'h0);
        chk("rst_qb", bus.Qb, 32'h0);
        chk("rst_busy_a", 32'(bus.Busy_a), 32'h0);
        chk("rst_npend", 32'(bus.Npend), 32'h0);

        // write attempted while in reset must be dropped
        bus.We = 1'b1;
        bus.Wr = 5'd5;
        bus.D  = 32'hDEAD_BEEF;
        step();
        idle();
        Clrn = 1'b1;
        step();
        chk("rst_write_dropped", bus.Qa, 32'h0);

        // write r7 with same-cycle bypass on both ports
        bus.We = 1'b1;
        bus.Wr = 5'd7;
        bus.D  = 32'h1234_5678;
        bus.Ra = 5'd7;
        bus.Rb = 5'd7;
        #1;
        chk("byp_qa", bus.Qa, 32'h1234_5678);
        chk("byp_qb", bus.Qb, 32'h1234_5678);
        step();
        idle();
        bus.D = 32'h0;
        #1;
        chk("stored_qa", bus.Qa, 32'h1234_5678);
        chk("stored_qb", bus.Qb, 32'h1234_5678);

        // zero register ignores write and issue
        bus.We  = 1'b1;
        bus.Wr  = 5'd0;
        bus.D   = 32'hFFFF_FFFF;
        bus.Iss = 1'b1;
        bus.Ird = 5'd0;
        bus.Ra  = 5'd0;
        #1;
        chk("r0_qa_byp", bus.Qa, 32'h0);
        chk("r0_busy_a", 32'(bus.Busy_a), 32'h0);
        step();
        idle();
        #1;
        chk("r0_qa", bus.Qa, 32'h0);
        chk("r0_npend", 32'(bus.Npend), 32'h0);

        // issue r3, then again, then writeback
        bus.Iss = 1'b1;
        bus.Ird = 5'd3;
        step();
        idle();
        bus.Ra = 5'd3;
        bus.Rb = 5'd3;
        #1;
        chk("iss3_busy_a", 32'(bus.Busy_a), 32'h1);
        chk("iss3_npend", 32'(bus.Npend), 32'h1);
        bus.Iss = 1'b1;
        step();
        idle();
        #1;
        chk("iss3_again_npend", 32'(bus.Npend), 32'h1);
        chk("iss3_again_busy_b", 32'(bus.Busy_b), 32'h1);
        bus.We = 1'b1;
        bus.Wr = 5'd3;
        bus.D  = 32'h0000_00AA;
        #1;
        chk("wb3_busy_a_byp", 32'(bus.Busy_a), 32'h0);
        chk("wb3_busy_b_byp", 32'(bus.Busy_b), 32'h0);
        chk("wb3_qa_byp", bus.Qa, 32'h0000_00AA);
        chk("wb3_npend_pre", 32'(bus.Npend), 32'h1);
        step();
        idle();
        #1;
        chk("wb3_npend", 32'(bus.Npend), 32'h0);
        chk("wb3_busy_a", 32'(bus.Busy_a), 32'h0);

        // writeback to a non-busy register
        bus.We = 1'b1;
        bus.Wr = 5'd12;
        bus.D  = 32'hCAFE_0012;
        step();
        idle();
        bus.Ra = 5'd12;
        #1;
        chk("wb12_qa", bus.Qa, 32'hCAFE_0012);
        chk("wb12_npend", 32'(bus.Npend), 32'h0);

        // busy r4 and r9, then writeback+issue r4 together
        bus.Iss = 1'b1;
        bus.Ird = 5'd4;
        step();
        bus.Ird = 5'd9;
        step();
        idle();
        #1;
        chk("r4r9_npend", 32'(bus.Npend), 32'h2);
        bus.We  = 1'b1;
        bus.Wr  = 5'd4;
        bus.D   = 32'h4444_4444;
        bus.Iss = 1'b1;
        bus.Ird = 5'd4;
        step();
        idle();
        bus.Ra = 5'd4;
        bus.Rb = 5'd9;
        #1;
        chk("wbiss4_busy_a", 32'(bus.Busy_a), 32'h1);
        chk("wbiss4_busy_b", 32'(bus.Busy_b), 32'h1);
        chk("wbiss4_npend", 32'(bus.Npend), 32'h2);
        chk("wbiss4_pop", 32'(bus.Npend), popcount(32'h0000_0210));
        chk("wbiss4_qa", bus.Qa, 32'h4444_4444);

        // flush with a same-cycle issue of r6
        bus.Flush = 1'b1;
        bus.Iss   = 1'b1;
        bus.Ird   = 5'd6;
        step();
        idle();
        bus.Ra = 5'd6;
        bus.Rb = 5'd4;
        #1;
        chk("flush_busy6", 32'(bus.Busy_a), 32'h1);
        chk("flush_busy4", 32'(bus.Busy_b), 32'h0);
        chk("flush_npend", 32'(bus.Npend), 32'h1);
        bus.Ra = 5'd9;
        #1;
        chk("flush_busy9", 32'(bus.Busy_a), 32'h0);

        // build up three pending, then pulse reset between edges
        bus.Iss = 1'b1;
        bus.Ird = 5'd2;
        step();
        bus.Ird = 5'd10;
        step();
        idle();
        bus.Ra = 5'd2;
        bus.Rb = 5'd10;
        #1;
        chk("pre_rst_npend", 32'(bus.Npend), 32'h3);
        chk("pre_rst_pop", 32'(bus.Npend), popcount(32'h0000_0444));
        chk("pre_rst_busy_a", 32'(bus.Busy_a), 32'h1);
        Clrn = 1'b0;
        #1;
        chk("mid_rst_npend", 32'(bus.Npend), 32'h0);
        chk("mid_rst_busy_a", 32'(bus.Busy_a), 32'h0);
        chk("mid_rst_busy_b", 32'(bus.Busy_b), 32'h0);
        bus.Ra = 5'd7;
        #1;
        chk("mid_rst_qa", bus.Qa, 32'h0);
        Clrn = 1'b1;
        step();
        chk("post_rst_npend", 32'(bus.Npend), 32'h0);
        chk("post_rst_qa", bus.Qa, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
